sixty_four_bit_csa_subtractor_iter: RTL and testbench
=====================================================

// Module: sixty_four_bit_csa_subtractor_iter
// PURPOSE
//   Multi-cycle carry-select subtractor: D = A - B - Bin, unsigned/two's-complement, WIDTH bits.
//   Each RUN cycle processes one SLICE-bit slice: both borrow-0 and borrow-1 slice differences
//   are formed, and the running borrow selects one. Borrow-out is the final slice's borrow.
//   Valid/ready on both sides; sits beside the 64-bit carry-select adders in the datapath
//   as the subtract path.
// PARAMETERS
//   WIDTH  64  operand/result width; must be an integer multiple of SLICE
//   SLICE  16  bits resolved per RUN cycle; NSLICE = WIDTH/SLICE (4 at defaults)
// PORTS
//   clk        input   1      rising-edge clock
//   rst_n      input   1      asynchronous reset, active low
//   in_valid   input   1      operands A, B, Bin valid
//   in_ready   output  1      block accepts operands (high only in IDLE)
//   A          input   WIDTH  minuend
//   B          input   WIDTH  subtrahend
//   Bin        input   1      borrow in
//   out_valid  output  1      result D/flags valid (high only in DONE)
//   out_ready  input   1      consumer takes result
//   D          output  WIDTH  difference, registered
//   B_Out      output  1      borrow out: 1 iff A < B + Bin (unsigned)
//   zero       output  1      D == 0
//   ovf        output  1      signed overflow: A[MSB]!=B[MSB] && D[MSB]!=A[MSB]
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, D=0, B_Out=0, zero=0, ovf=0, out_valid=0,
//     slice index k=0, internal borrow=0; in_ready=1 (decoded from IDLE).
//   Reset mid-operation aborts the op with no output; the first edge after release is IDLE.
//   FSM IDLE -> RUN -> DONE -> IDLE; in_ready = (state==IDLE), out_valid = (state==DONE).
//   IDLE: on edge with in_valid&&in_ready: latch A, B; borrow<=Bin; k<=0; D<=0; -> RUN.
//     in_valid ignored in RUN and DONE; no operand overlap.
//   RUN, each edge: d0 = A_k - B_k, d1 = A_k - B_k - 1 (SLICE-bit, borrow-outs b0/b1);
//     D slice k <= borrow ? d1 : d0; borrow <= borrow ? b1 : b0; k<=k+1.
//     On slice k==NSLICE-1: B_Out<=selected borrow, zero/ovf from final D -> DONE.
//   Latency: accept at edge T; out_valid high after edge T+NSLICE (4 at defaults).
//   DONE: D, B_Out, zero, ovf held stable while out_ready=0 (indefinite backpressure).
//     Edge with out_ready=1 -> IDLE; out_valid drops, in_ready rises the same edge.
//     D/flags retain their value in IDLE until the next RUN clears D.
//   Arithmetic: mod 2^WIDTH, no saturation; Bin=1 with A==B gives all-ones, B_Out=1.
//   Throughput: one result per NSLICE+2 cycles with out_ready held high.
// TESTING
//   A=5, B=3, Bin=0 -> D=2, B_Out=0, zero=0, ovf=0; out_valid exactly 4 cycles after accept.
//   A=0, B=1, Bin=0 -> D=64'hFFFF_FFFF_FFFF_FFFF, B_Out=1 (borrow ripples all 4 slices).
//   A=64'h8000_0000_0000_0000, B=1 -> D=64'h7FFF_FFFF_FFFF_FFFF, ovf=1, B_Out=0.
//   A=B=64'h1234_5678_9ABC_DEF0: Bin=0 -> D=0, zero=1; Bin=1 -> D=all ones, B_Out=1, zero=0.
//   out_ready=0 for 5 cycles in DONE, in_valid=1 with new operands -> D/flags unchanged,
//     in_ready=0, new operands not taken; out_ready=1 -> IDLE next edge, then new op accepted.
//   rst_n pulsed low mid-RUN -> out_valid=0, in_ready=1 immediately; then 1000 random
//     operand sets with random Bin/out_ready stalls vs. {B_Out,D} = {1'b0,A}-B-Bin model.

Source files
------------

// File: rtl/sixty_four_bit_csa_subtractor_iter_if.sv
// Operand/result handshake bundle for the iterative carry-select subtractor.
interface sixty_four_bit_csa_subtractor_iter_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             B_Out;
    logic             zero;
    logic             ovf;

    // Producer/consumer side of the block
    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, D, B_Out, zero, ovf
    );

    // The subtractor itself
    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, D, B_Out, zero, ovf
    );
endinterface

// File: rtl/sixty_four_bit_csa_subtractor_iter.sv
// Multi-cycle carry-select subtractor: D = A - B - Bin, one SLICE-bit slice per RUN cycle.
// Both borrow-0 and borrow-1 slice differences are formed; the running borrow picks one.
module sixty_four_bit_csa_subtractor_iter #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    sixty_four_bit_csa_subtractor_iter_if.slave   bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             borrow;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] d_r;
    logic             b_out_r;
    logic             zero_r;
    logic             ovf_r;

    logic [IW-1:0]    base;
    logic [SLICE-1:0] a_k;
    logic [SLICE-1:0] b_k;
    logic [SLICE:0]   diff0;
    logic [SLICE:0]   diff1;
    logic [SLICE-1:0] d_sel;
    logic             b_sel;
    logic [WIDTH-1:0] d_next;

    // Slice datapath: both borrow hypotheses, selected by the running borrow
    always_comb begin
        base   = IW'(k) * IW'(SLICE);
        a_k    = a_r[base +: SLICE];
        b_k    = b_r[base +: SLICE];
        diff0  = {1'b0, a_k} - {1'b0, b_k};
        diff1  = {1'b0, a_k} - {1'b0, b_k} - {{SLICE{1'b0}}, 1'b1};
        d_sel  = borrow ? diff1[SLICE-1:0] : diff0[SLICE-1:0];
        b_sel  = borrow ? diff1[SLICE] : diff0[SLICE];
        d_next = d_r;
        d_next[base +: SLICE] = d_sel;
    end

    // Control FSM and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            borrow  <= 1'b0;
            k       <= '0;
            d_r     <= '0;
            b_out_r <= 1'b0;
            zero_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r    <= bus.A;
                        b_r    <= bus.B;
                        borrow <= bus.Bin;
                        k      <= '0;
                        d_r    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    d_r    <= d_next;
                    borrow <= b_sel;
                    if (k == KW'(NSLICE - 1)) begin
                        k       <= '0;
                        b_out_r <= b_sel;
                        zero_r  <= (d_next == '0);
                        ovf_r   <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                                   (d_next[WIDTH-1] != a_r[WIDTH-1]);
                        state   <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.D         = d_r;
    assign bus.B_Out     = b_out_r;
    assign bus.zero      = zero_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_sixty_four_bit_csa_subtractor_iter.sv
// Scoreboard bench for the iterative carry-select subtractor.
module tb_sixty_four_bit_csa_subtractor_iter;
    logic clk;
    logic rst_n;

    sixty_four_bit_csa_subtractor_iter_if #(.WIDTH(64)) bus ();

    sixty_four_bit_csa_subtractor_iter #(.WIDTH(64), .SLICE(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] d;
        logic        bo;
        logic        z;
        logic        ov;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   lat_done = 0;
    bit   rand_stall = 0;
    logic or_dir = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Single driver of out_ready: directed level or random stalls
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rand_stall ? ($urandom_range(0, 3) != 0) : or_dir;
        end
    end

    // Monitor: compare every presented result against the queue head, pop on handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    e = q[0];
                    if (!lat_done) begin
                        chk("latency", 64'(cyc - e.acc), 64'd4);
                        lat_done = 1;
                    end
                    chk("D", bus.D, e.d);
                    chk("B_Out", {63'd0, bus.B_Out}, {63'd0, e.bo});
                    chk("zero", {63'd0, bus.zero}, {63'd0, e.z});
                    chk("ovf", {63'd0, bus.ovf}, {63'd0, e.ov});
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        lat_done = 0;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic bin,
                         input bit push, input exp_t e_in);
        exp_t e;
        int   n;
        e = e_in;
        n = 0;
        bus.A = a;
        bus.B = b;
        bus.Bin = bin;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 100) begin
                chk("accept_timeout", 64'd1, 64'd0);
                bus.in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        e.acc = cyc;
        if (push) q.push_back(e);
    endtask

    task automatic send_exp(input logic [63:0] a, input logic [63:0] b, input logic bin,
                            input logic [63:0] d, input logic bo, input logic z, input logic ov);
        exp_t e;
        e.d = d; e.bo = bo; e.z = z; e.ov = ov; e.acc = 0;
        issue(a, b, bin, 1'b1, e);
    endtask

    // Reference: {borrow, D} = {1'b0,A} - B - Bin; overflow from operand/result signs
    task automatic send_model(input logic [63:0] a, input logic [63:0] b, input logic bin);
        exp_t e;
        logic [64:0] r;
        r = {1'b0, a} - {1'b0, b} - {64'd0, bin};
        e.d = r[63:0];
        e.bo = r[64];
        e.z = (r[63:0] == 64'd0);
        e.ov = (a[63] != b[63]) && (r[63] != a[63]);
        e.acc = 0;
        issue(a, b, bin, 1'b1, e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                chk("drain_timeout", 64'(q.size()), 64'd0);
                q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t dummy;
        int   n;
        dummy.d = '0; dummy.bo = 0; dummy.z = 0; dummy.ov = 0; dummy.acc = 0;
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Bin = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_D", bus.D, 64'd0);
        chk("rst_flags", {61'd0, bus.B_Out, bus.zero, bus.ovf}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors
        send_exp(64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);
        drain();
        send_exp(64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        drain();
        send_exp(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
        drain();
        send_exp(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        drain();
        send_exp(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        drain();

        // Backpressure in DONE with competing operands on the input
        or_dir = 1'b0;
        @(posedge clk);
        #1;
        send_exp(64'd100, 64'd1, 1'b0, 64'd99, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached_done", {63'd0, bus.out_valid}, 64'd1);
        @(posedge clk);
        #1;
        bus.A = 64'd7;
        bus.B = 64'd2;
        bus.Bin = 1'b0;
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        or_dir = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("release_out_valid", {63'd0, bus.out_valid}, 64'd0);
        send_exp(64'd7, 64'd2, 1'b0, 64'd5, 1'b0, 1'b0, 1'b0);
        drain();

        // Reset mid-RUN aborts with no result
        issue(64'd9, 64'd4, 1'b0, 1'b0, dummy);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random operands with random consumer stalls
        rand_stall = 1;
        for (int i = 0; i < 1000; i++) begin
            send_model({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        drain();
        rand_stall = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
